// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and default widths for the
// instruction-fetch sequencer and its next-PC selector.
package fetch_sequencer_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam int DEFAULT_N   = 32;
    localparam int DEFAULT_INC = 4;

    localparam fetch_state_t S_INIT = 2'b00;
    localparam fetch_state_t S_REQ  = 2'b01;
    localparam fetch_state_t S_OUT  = 2'b10;

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// pc_next_sel: next-PC selection for the fetch sequencer. Chooses between the
// sequential successor of the current PC and a redirect target.
module pc_next_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int INC = DEFAULT_INC
) (
    input  logic [N-1:0] i_pc,
    input  logic         i_branchEn,
    input  logic [N-1:0] i_branchTarget,
    output logic [N-1:0] o_pcNext
);

    // Redirect wins over the sequential step; the increment wraps modulo 2^N.
    always_comb begin
        o_pcNext = i_branchEn ? i_branchTarget : (i_pc + N'(INC));
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: reads the PC, requests the instruction word from memory,
// holds it for the decoder and writes back the next PC on acceptance.
// Optional build macro FETCH_TIMEOUT_EN adds a memory-ack watchdog that raises
// a sticky o_fetchErr and restarts fetching from RESET_PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int             N        = DEFAULT_N,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter int             INC      = DEFAULT_INC,
    parameter int             TIMEOUT  = 15
) (
    input  logic         i_clk,
    input  logic         i_rst_,
    input  logic [N-1:0] i_pc,
    output logic         o_pcReadEn,
    output logic [N-1:0] o_pcNext,
    output logic         o_pcWriteEn,
    output logic         o_memReq,
    output logic [N-1:0] o_memAddr,
    input  logic         i_memAck,
    input  logic [N-1:0] i_memData,
    output logic [N-1:0] o_instr,
    output logic         o_instrValid,
    input  logic         i_instrReady,
    input  logic         i_branchEn,
    input  logic [N-1:0] i_branchTarget,
    output logic         o_fetchErr
);

    // A watchdog that can never count a single cycle is a configuration error.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT must be at least 1");
    end

    fetch_state_t state_q, state_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_sel;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fetch_err_q, fetch_err_d;
`endif

    pc_next_sel #(
        .N   (N),
        .INC (INC)
    ) u_pc_next_sel (
        .i_pc           (i_pc),
        .i_branchEn     (i_branchEn),
        .i_branchTarget (i_branchTarget),
        .o_pcNext       (pc_sel)
    );

    // Next-state logic: wait for the memory ack, then hold the word until the decoder takes it.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = '0;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            S_INIT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (i_memAck) begin
                    instr_d = i_memData;
                    state_d = S_OUT;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_INIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_OUT: begin
                if (i_instrReady) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and instruction latch, cleared by the synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            state_q <= S_INIT;
            instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    // Handshake and PC-write outputs; all quiet while reset is held low.
    always_comb begin
        o_pcReadEn   = 1'b0;
        o_memReq     = 1'b0;
        o_memAddr    = '0;
        o_instrValid = 1'b0;
        o_pcWriteEn  = 1'b0;
        o_pcNext     = '0;
        if (i_rst_) begin
            case (state_q)
                S_INIT: begin
                    o_pcWriteEn = 1'b1;
                    o_pcNext    = RESET_PC;
                end
                S_REQ: begin
                    o_pcReadEn = 1'b1;
                    o_memReq   = 1'b1;
                    o_memAddr  = i_pc;
                end
                S_OUT: begin
                    o_pcReadEn   = 1'b1;
                    o_instrValid = 1'b1;
                    if (i_instrReady) begin
                        o_pcWriteEn = 1'b1;
                        o_pcNext    = pc_sel;
                    end
                end
                default: begin
                    o_pcReadEn = 1'b0;
                end
            endcase
        end
    end

    assign o_instr = instr_q;

`ifdef FETCH_TIMEOUT_EN
    assign o_fetchErr = fetch_err_q;
`else
    assign o_fetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer. The bench plays
// the PC register and the instruction memory, and predicts fetch addresses,
// latched words and next-PC values from the handshake rules with plain arithmetic.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk          = 1'b0;
    logic        i_rst_         = 1'b0;
    logic [31:0] i_pc;
    logic        o_pcReadEn;
    logic [31:0] o_pcNext;
    logic        o_pcWriteEn;
    logic        o_memReq;
    logic [31:0] o_memAddr;
    logic        i_memAck       = 1'b0;
    logic [31:0] i_memData      = '0;
    logic [31:0] o_instr;
    logic        o_instrValid;
    logic        i_instrReady   = 1'b0;
    logic        i_branchEn     = 1'b0;
    logic [31:0] i_branchTarget = '0;
    logic        o_fetchErr;

    int          num_checks = 0;
    int          num_fails  = 0;
    logic [31:0] pc_reg     = 32'hDEAD_BEEF;
    logic [31:0] model_pc   = '0;

    fetch_sequencer dut (
        .i_clk          (i_clk),
        .i_rst_         (i_rst_),
        .i_pc           (i_pc),
        .o_pcReadEn     (o_pcReadEn),
        .o_pcNext       (o_pcNext),
        .o_pcWriteEn    (o_pcWriteEn),
        .o_memReq       (o_memReq),
        .o_memAddr      (o_memAddr),
        .i_memAck       (i_memAck),
        .i_memData      (i_memData),
        .o_instr        (o_instr),
        .o_instrValid   (o_instrValid),
        .i_instrReady   (i_instrReady),
        .i_branchEn     (i_branchEn),
        .i_branchTarget (i_branchTarget),
        .o_fetchErr     (o_fetchErr)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Stand-in for the PC register upstream of the sequencer.
    always @(posedge i_clk) begin
        if (o_pcWriteEn) pc_reg <= o_pcNext;
    end
    assign i_pc = pc_reg;

    // Hard stop in case the bench itself ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Architectural next PC: redirect target, else PC+4 modulo 2^32.
    function automatic logic [31:0] exp_next(input logic [31:0] pc, input logic br, input logic [31:0] tgt);
        logic [63:0] s;
        s = ({32'b0, pc} + 64'd4) % 64'h1_0000_0000;
        return br ? tgt : s[31:0];
    endfunction

    // Drive one cycle's inputs at the falling edge and settle before sampling.
    task automatic drive_cycle(input logic rst_n, input logic ack, input logic [31:0] data,
                               input logic ready, input logic br, input logic [31:0] tgt);
        @(negedge i_clk);
        i_rst_         = rst_n;
        i_memAck       = ack;
        i_memData      = data;
        i_instrReady   = ready;
        i_branchEn     = br;
        i_branchTarget = tgt;
        #1;
    endtask

    // Reset holds everything quiet, then a single PC write of RESET_PC follows release.
    task automatic test_reset();
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, '0);
        num_checks++; if (o_memReq !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_memReq: got %b want 0", o_memReq); end
        num_checks++; if (o_instrValid !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_valid: got %b want 0", o_instrValid); end
        num_checks++; if (o_instr !== 32'h0) begin num_fails++; $display("[TB] FAIL rst_instr: got %h want 0", o_instr); end
        num_checks++; if (o_pcWriteEn !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_wen: got %b want 0", o_pcWriteEn); end
        num_checks++; if (o_pcReadEn !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_ren: got %b want 0", o_pcReadEn); end
        num_checks++; if (o_fetchErr !== 1'b0) begin num_fails++; $display("[TB] FAIL rst_err: got %b want 0", o_fetchErr); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL init_wen: got %b want 1", o_pcWriteEn); end
        num_checks++; if (o_pcNext !== RESET_PC) begin num_fails++; $display("[TB] FAIL init_pcNext: got %h want %h", o_pcNext, RESET_PC); end
        num_checks++; if (o_memReq !== 1'b0) begin num_fails++; $display("[TB] FAIL init_memReq: got %b want 0", o_memReq); end
        model_pc = RESET_PC;
    endtask

    // Same-cycle ack with ready held high: fetch addresses 0,4,8,12, one word per two cycles.
    task automatic test_sequential();
        logic [31:0] data;
        logic [31:0] np;
        for (int i = 0; i < 4; i++) begin
            data = $urandom;
            drive_cycle(1'b1, 1'b1, data, 1'b1, 1'b0, '0);
            num_checks++; if (o_memReq !== 1'b1) begin num_fails++; $display("[TB] FAIL seq_memReq: got %b want 1", o_memReq); end
            num_checks++; if (o_memAddr !== 32'(4 * i)) begin num_fails++; $display("[TB] FAIL seq_addr: got %h want %h", o_memAddr, 32'(4 * i)); end
            num_checks++; if (o_pcReadEn !== 1'b1) begin num_fails++; $display("[TB] FAIL seq_ren: got %b want 1", o_pcReadEn); end
            num_checks++; if (o_instrValid !== 1'b0) begin num_fails++; $display("[TB] FAIL seq_valid_req: got %b want 0", o_instrValid); end
            drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
            np = exp_next(model_pc, 1'b0, '0);
            num_checks++; if (o_instrValid !== 1'b1) begin num_fails++; $display("[TB] FAIL seq_valid_out: got %b want 1", o_instrValid); end
            num_checks++; if (o_instr !== data) begin num_fails++; $display("[TB] FAIL seq_instr: got %h want %h", o_instr, data); end
            num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL seq_wen: got %b want 1", o_pcWriteEn); end
            num_checks++; if (o_pcNext !== np) begin num_fails++; $display("[TB] FAIL seq_pcNext: got %h want %h", o_pcNext, np); end
            model_pc = np;
        end
    endtask

    // Ack arrives after three idle request cycles; request and address must hold meanwhile.
    task automatic test_ack_delay();
        logic [31:0] data;
        logic [31:0] np;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
            num_checks++; if (o_memReq !== 1'b1) begin num_fails++; $display("[TB] FAIL dly_memReq: got %b want 1", o_memReq); end
            num_checks++; if (o_memAddr !== model_pc) begin num_fails++; $display("[TB] FAIL dly_addr: got %h want %h", o_memAddr, model_pc); end
        end
        data = $urandom;
        drive_cycle(1'b1, 1'b1, data, 1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, ~data, 1'b1, 1'b0, '0);
        np = exp_next(model_pc, 1'b0, '0);
        num_checks++; if (o_instr !== data) begin num_fails++; $display("[TB] FAIL dly_instr: got %h want %h", o_instr, data); end
        num_checks++; if (o_pcNext !== np) begin num_fails++; $display("[TB] FAIL dly_pcNext: got %h want %h", o_pcNext, np); end
        model_pc = np;
    endtask

    // Decoder stalls four cycles: word stays put, stray ack and branch are ignored.
    task automatic test_ready_stall();
        logic [31:0] data;
        logic [31:0] np;
        data = $urandom;
        drive_cycle(1'b1, 1'b1, data, 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, 1'b1, ~data, 1'b0, 1'b1, 32'h0000_0300);
            num_checks++; if (o_instrValid !== 1'b1) begin num_fails++; $display("[TB] FAIL stall_valid: got %b want 1", o_instrValid); end
            num_checks++; if (o_instr !== data) begin num_fails++; $display("[TB] FAIL stall_instr: got %h want %h", o_instr, data); end
            num_checks++; if (o_pcWriteEn !== 1'b0) begin num_fails++; $display("[TB] FAIL stall_wen: got %b want 0", o_pcWriteEn); end
            num_checks++; if (o_pcNext !== 32'h0) begin num_fails++; $display("[TB] FAIL stall_pcNext: got %h want 0", o_pcNext); end
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        np = exp_next(model_pc, 1'b0, '0);
        num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL stall_release_wen: got %b want 1", o_pcWriteEn); end
        num_checks++; if (o_pcNext !== np) begin num_fails++; $display("[TB] FAIL stall_release_pcNext: got %h want %h", o_pcNext, np); end
        model_pc = np;
    endtask

    // Branch outside the accept cycle is ignored; branch on accept redirects to 0x100.
    task automatic test_branch();
        drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b1, 32'h0000_0200);
        num_checks++; if (o_pcWriteEn !== 1'b0) begin num_fails++; $display("[TB] FAIL br_req_wen: got %b want 0", o_pcWriteEn); end
        num_checks++; if (o_pcNext !== 32'h0) begin num_fails++; $display("[TB] FAIL br_req_pcNext: got %h want 0", o_pcNext); end
        drive_cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b1, 32'h0000_0200);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0100);
        num_checks++; if (o_pcNext !== 32'h0000_0100) begin num_fails++; $display("[TB] FAIL br_pcNext: got %h want 00000100", o_pcNext); end
        model_pc = exp_next(model_pc, 1'b1, 32'h0000_0100);
        drive_cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b0, '0);
        num_checks++; if (o_memAddr !== 32'h0000_0100) begin num_fails++; $display("[TB] FAIL br_addr: got %h want 00000100", o_memAddr); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        model_pc = exp_next(model_pc, 1'b0, '0);
        num_checks++; if (o_pcNext !== model_pc) begin num_fails++; $display("[TB] FAIL br_seq_pcNext: got %h want %h", o_pcNext, model_pc); end
    endtask

    // Fetch at the top of the address space; the sequential step wraps to zero.
    task automatic test_wrap();
        drive_cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        model_pc = 32'hFFFF_FFFC;
        drive_cycle(1'b1, 1'b1, $urandom, 1'b1, 1'b0, '0);
        num_checks++; if (o_memAddr !== 32'hFFFF_FFFC) begin num_fails++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", o_memAddr); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        model_pc = exp_next(model_pc, 1'b0, '0);
        num_checks++; if (o_pcNext !== model_pc) begin num_fails++; $display("[TB] FAIL wrap_pcNext: got %h want %h", o_pcNext, model_pc); end
    endtask

    // Long memory silence: watchdog error and restart when enabled, otherwise an indefinite wait.
    task automatic test_no_ack_wait();
`ifdef FETCH_TIMEOUT_EN
        logic [31:0] data;
        for (int k = 0; k < 15; k++) begin
            drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
            num_checks++; if (o_fetchErr !== 1'b0) begin num_fails++; $display("[TB] FAIL to_err_early: got %b want 0", o_fetchErr); end
        end
        drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
        num_checks++; if (o_fetchErr !== 1'b1) begin num_fails++; $display("[TB] FAIL to_err: got %b want 1", o_fetchErr); end
        num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL to_wen: got %b want 1", o_pcWriteEn); end
        num_checks++; if (o_pcNext !== RESET_PC) begin num_fails++; $display("[TB] FAIL to_pcNext: got %h want %h", o_pcNext, RESET_PC); end
        model_pc = RESET_PC;
        data = $urandom;
        drive_cycle(1'b1, 1'b1, data, 1'b1, 1'b0, '0);
        num_checks++; if (o_memAddr !== RESET_PC) begin num_fails++; $display("[TB] FAIL to_refetch_addr: got %h want %h", o_memAddr, RESET_PC); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        num_checks++; if (o_instr !== data) begin num_fails++; $display("[TB] FAIL to_instr: got %h want %h", o_instr, data); end
        num_checks++; if (o_fetchErr !== 1'b1) begin num_fails++; $display("[TB] FAIL to_sticky: got %b want 1", o_fetchErr); end
        model_pc = exp_next(model_pc, 1'b0, '0);
`else
        for (int k = 0; k < 20; k++) begin
            drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
            num_checks++; if (o_memReq !== 1'b1) begin num_fails++; $display("[TB] FAIL wait_memReq: got %b want 1", o_memReq); end
            num_checks++; if (o_fetchErr !== 1'b0) begin num_fails++; $display("[TB] FAIL wait_err: got %b want 0", o_fetchErr); end
        end
`endif
    endtask

    // Reset while a request is outstanding drops it and restarts from RESET_PC.
    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0, '0);
        num_checks++; if (o_memReq !== 1'b1) begin num_fails++; $display("[TB] FAIL rmid_pre_memReq: got %b want 1", o_memReq); end
        drive_cycle(1'b0, 1'b0, $urandom, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, $urandom, 1'b1, 1'b0, '0);
        num_checks++; if (o_memReq !== 1'b0) begin num_fails++; $display("[TB] FAIL rmid_memReq: got %b want 0", o_memReq); end
        num_checks++; if (o_instr !== 32'h0) begin num_fails++; $display("[TB] FAIL rmid_instr: got %h want 0", o_instr); end
        num_checks++; if (o_fetchErr !== 1'b0) begin num_fails++; $display("[TB] FAIL rmid_err: got %b want 0", o_fetchErr); end
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL rmid_wen: got %b want 1", o_pcWriteEn); end
        num_checks++; if (o_pcNext !== RESET_PC) begin num_fails++; $display("[TB] FAIL rmid_pcNext: got %h want %h", o_pcNext, RESET_PC); end
        model_pc = RESET_PC;
    endtask

    // Random acks, stalls and redirects against the transaction-level PC model.
    task automatic test_random_stream();
        logic        presenting;
        logic [31:0] word, data, tgt, np;
        logic        ack, ready, br;
        int          waited;
        presenting = 1'b0;
        waited     = 0;
        word       = '0;
        for (int c = 0; c < 300; c++) begin
            data  = $urandom;
            tgt   = $urandom & 32'hFFFF_FFFC;
            br    = ($urandom % 4) == 0;
            ready = ($urandom % 2) == 0;
            if (presenting) ack = ($urandom % 3) == 0;
            else            ack = (($urandom % 2) == 0) || (waited >= 6);
            drive_cycle(1'b1, ack, data, ready, br, tgt);
            if (presenting) begin
                num_checks++; if (o_instrValid !== 1'b1) begin num_fails++; $display("[TB] FAIL rnd_valid: cycle %0d got %b want 1", c, o_instrValid); end
                num_checks++; if (o_instr !== word) begin num_fails++; $display("[TB] FAIL rnd_instr: cycle %0d got %h want %h", c, o_instr, word); end
                if (ready) begin
                    np = exp_next(model_pc, br, tgt);
                    num_checks++; if (o_pcWriteEn !== 1'b1) begin num_fails++; $display("[TB] FAIL rnd_wen: cycle %0d got %b want 1", c, o_pcWriteEn); end
                    num_checks++; if (o_pcNext !== np) begin num_fails++; $display("[TB] FAIL rnd_pcNext: cycle %0d got %h want %h", c, o_pcNext, np); end
                    model_pc   = np;
                    presenting = 1'b0;
                    waited     = 0;
                end else begin
                    num_checks++; if (o_pcWriteEn !== 1'b0) begin num_fails++; $display("[TB] FAIL rnd_stall_wen: cycle %0d got %b want 0", c, o_pcWriteEn); end
                end
            end else begin
                num_checks++; if (o_memReq !== 1'b1) begin num_fails++; $display("[TB] FAIL rnd_memReq: cycle %0d got %b want 1", c, o_memReq); end
                num_checks++; if (o_memAddr !== model_pc) begin num_fails++; $display("[TB] FAIL rnd_addr: cycle %0d got %h want %h", c, o_memAddr, model_pc); end
                num_checks++; if (o_pcWriteEn !== 1'b0) begin num_fails++; $display("[TB] FAIL rnd_req_wen: cycle %0d got %b want 0", c, o_pcWriteEn); end
                if (ack) begin
                    word       = data;
                    presenting = 1'b1;
                end else begin
                    waited++;
                end
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_ready_stall();
        test_branch();
        test_wrap();
        test_no_ack_wait();
        test_reset_mid();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
